mq_buffer_ctrl: RTL

MQ_BUFFER_CTRL -- requirements
Module: mq_buffer_ctrl

---
 rtl/mq_buffer_ctrl.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/mq_buffer_ctrl.sv
// mq_buffer_ctrl: data store and output stage for a multi-queue buffer.
// The slot bookkeeping is done by an external linked-list pointer manager
// reached through the ll_* ports. This block does three things: it holds the
// payload array, writes a payload into the free slot the manager offers, and
// arbitrates one non-empty list into a one-entry output register.
//
// Optional feature macro: MQ_BUFFER_CTRL_STRICT_PRIO_EN
//   undefined : round-robin arbitration between lists (default)
//   defined   : fixed priority, the lowest-index non-empty list wins, no rr_ptr
module mq_buffer_ctrl #(
  parameter int NUM_ELEMS  = 4,
  parameter int NUM_LISTS  = 2,
  parameter int DATA_WIDTH = 8,
  parameter int PTR_WIDTH  = $clog2(NUM_ELEMS),
  parameter int LIST_WIDTH = $clog2(NUM_LISTS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enq_valid,
  output logic                  enq_ready,
  input  logic [LIST_WIDTH-1:0] enq_list,
  input  logic [DATA_WIDTH-1:0] enq_data,
  output logic                  deq_valid,
  input  logic                  deq_ready,
  output logic [LIST_WIDTH-1:0] deq_list,
  output logic [DATA_WIDTH-1:0] deq_data,
  output logic [NUM_LISTS-1:0]  ll_push,
  output logic [NUM_LISTS-1:0]  ll_pop,
  input  logic                  ll_full,
  input  logic [NUM_LISTS-1:0]  ll_empty,
  input  logic [PTR_WIDTH-1:0]  ll_free_ptr,
  input  logic [PTR_WIDTH-1:0]  ll_popped_head
);

  // Width-matched copy of NUM_LISTS for the out-of-range list check.
  localparam logic [LIST_WIDTH:0] LIST_LIMIT = (LIST_WIDTH + 1)'(NUM_LISTS);

  // Shared payload store. It is deliberately not reset: a slot is only ever
  // read after the pointer manager has handed it out and it has been written.
  logic [DATA_WIDTH-1:0] mem_r [NUM_ELEMS];

  logic                  deq_valid_r;
  logic [LIST_WIDTH-1:0] deq_list_r;
  logic [DATA_WIDTH-1:0] deq_data_r;

  logic                  enq_fire_s;
  logic                  enq_in_range_s;
  logic                  write_s;
  logic                  slot_free_s;
  logic                  any_nonempty_s;
  logic                  pop_s;
  logic                  found_s;
  logic [LIST_WIDTH-1:0] start_s;
  logic [LIST_WIDTH-1:0] cand_s;
  logic [LIST_WIDTH-1:0] grant_s;

`ifndef MQ_BUFFER_CTRL_STRICT_PRIO_EN
  logic [LIST_WIDTH-1:0] rr_ptr_r;
`endif

  // A full manager blocks enqueue even if a pop frees a slot this cycle.
  assign enq_ready = !ll_full;

  // Accept and write decode. Requests to a list that does not exist are
  // accepted and dropped so the producer never stalls on them.
  always_comb begin
    enq_fire_s     = enq_valid & enq_ready;
    enq_in_range_s = ({1'b0, enq_list} < LIST_LIMIT);
    write_s        = rst & enq_fire_s & enq_in_range_s;
    slot_free_s    = !deq_valid_r | deq_ready;
    any_nonempty_s = |(~ll_empty);
    pop_s          = rst & slot_free_s & any_nonempty_s;
  end

  // Arbiter: scan the lists starting at start_s and take the first non-empty.
  always_comb begin
`ifdef MQ_BUFFER_CTRL_STRICT_PRIO_EN
    start_s = {LIST_WIDTH{1'b0}};
`else
    start_s = rr_ptr_r;
`endif
    found_s = 1'b0;
    cand_s  = {LIST_WIDTH{1'b0}};
    grant_s = {LIST_WIDTH{1'b0}};
    for (int i = 0; i < NUM_LISTS; i++) begin
      cand_s = LIST_WIDTH'((int'(start_s) + i) % NUM_LISTS);
      if (!found_s && !ll_empty[cand_s]) begin
        found_s = 1'b1;
        grant_s = cand_s;
      end else begin
        found_s = found_s;
      end
    end
  end

  // Pointer manager strobes; both stay low while reset is asserted.
  always_comb begin
    ll_push = {NUM_LISTS{1'b0}};
    ll_pop  = {NUM_LISTS{1'b0}};
    if (write_s) begin
      ll_push[enq_list] = 1'b1;
    end else begin
      ll_push = {NUM_LISTS{1'b0}};
    end
    if (pop_s) begin
      ll_pop[grant_s] = 1'b1;
    end else begin
      ll_pop = {NUM_LISTS{1'b0}};
    end
  end

  // Payload write into the slot the manager offers as free.
  always_ff @(posedge clk) begin
    if (write_s) begin
      mem_r[ll_free_ptr] <= enq_data;
    end else begin
      mem_r[ll_free_ptr] <= mem_r[ll_free_ptr];
    end
  end

  // One-entry output register: reload on a pop, drain on consume, else hold.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      deq_valid_r <= 1'b0;
      deq_list_r  <= {LIST_WIDTH{1'b0}};
      deq_data_r  <= {DATA_WIDTH{1'b0}};
    end else if (pop_s) begin
      deq_valid_r <= 1'b1;
      deq_list_r  <= grant_s;
      deq_data_r  <= mem_r[ll_popped_head];
    end else if (deq_ready) begin
      deq_valid_r <= 1'b0;
    end else begin
      deq_valid_r <= deq_valid_r;
    end
  end

`ifndef MQ_BUFFER_CTRL_STRICT_PRIO_EN
  // Round-robin pointer: the list after the last grant gets first look next.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr_r <= {LIST_WIDTH{1'b0}};
    end else if (pop_s) begin
      rr_ptr_r <= LIST_WIDTH'((int'(grant_s) + 1) % NUM_LISTS);
    end else begin
      rr_ptr_r <= rr_ptr_r;
    end
  end
`endif

  assign deq_valid = deq_valid_r;
  assign deq_list  = deq_list_r;
  assign deq_data  = deq_data_r;

endmodule
